// File: rtl/tdes_round_ctrl.sv
// Round/pass sequencer for a DES/3DES datapath: drives the IP load, key schedule,
// 16 Feistel rounds per pass and the final permutation capture.
module tdes_round_ctrl #(
  parameter int unsigned PASSES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dec,
  input  logic       hold,
  output logic       ready,
  output logic       busy,
  output logic       load,
  output logic       key_load,
  output logic [1:0] key_sel,
  output logic [1:0] pass,
  output logic       mode_dec,
  output logic       rnd_en,
  output logic [3:0] round,
  output logic [1:0] shift_amt,
  output logic       fp_en,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    KEY,
    FINAL
  } state_t;

  localparam logic [1:0] LAST_PASS = 2'(PASSES - 1);

  state_t     state_q, state_d;
  logic [1:0] pass_q, pass_d;
  logic [3:0] round_q, round_d;
  logic       dec_q, dec_d;
  logic       done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pass_q  <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      round_q <= round_d;
      dec_q   <= dec_d;
      done_q  <= done_d;
    end
  end

  // pass/round advance on the edge into KEY so that KEY already presents
  // the next pass's key_sel and mode_dec alongside its key_load strobe.
  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    round_d = round_q;
    dec_d   = dec_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          pass_d  = '0;
          round_d = '0;
          dec_d   = dec;
        end
      end
      LOAD: begin
        if (!hold) state_d = ROUND;
      end
      ROUND: begin
        if (!hold) begin
          if (round_q == 4'd15) begin
            round_d = '0;
            if (pass_q != LAST_PASS) begin
              pass_d  = 2'(pass_q + 2'd1);
              state_d = KEY;
            end else begin
              state_d = FINAL;
            end
          end else begin
            round_d = 4'(round_q + 4'd1);
          end
        end
      end
      KEY: begin
        if (!hold) state_d = ROUND;
      end
      FINAL: begin
        if (!hold) begin
          state_d = IDLE;
          pass_d  = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic in_idle, in_load, in_round, in_key, in_final;
  logic key_active;

  assign in_idle  = (state_q == IDLE);
  assign in_load  = (state_q == LOAD);
  assign in_round = (state_q == ROUND);
  assign in_key   = (state_q == KEY);
  assign in_final = (state_q == FINAL);
  assign key_active = in_load | in_key | in_round;

  assign ready    = in_idle;
  assign busy     = ~in_idle;
  assign load     = in_load & ~hold;
  assign key_load = (in_load | in_key) & ~hold;
  assign rnd_en   = in_round & ~hold;
  assign fp_en    = in_final & ~hold;
  assign done     = done_q;
  assign pass     = pass_q;
  assign round    = round_q;

  // EDE ordering: passes alternate direction, decrypt walks the keys backwards.
  assign mode_dec = busy & (dec_q ^ pass_q[0]);
  assign key_sel  = !key_active ? 2'd0 : (dec_q ? 2'(LAST_PASS - pass_q) : pass_q);

  always_comb begin
    shift_amt = 2'd0;
    if (in_round) begin
      if (round_q == 4'd0)
        shift_amt = mode_dec ? 2'd0 : 2'd1;
      else if (round_q == 4'd1 || round_q == 4'd8 || round_q == 4'd15)
        shift_amt = 2'd1;
      else
        shift_amt = 2'd2;
    end
  end

endmodule

// File: tb/tb_tdes_round_ctrl.sv
// Bench for tdes_round_ctrl: per-cycle comparison of both PASSES variants against
// an expected trace built from the pass/shift tables.
module tb_tdes_round_ctrl;

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       load;
    logic       key_load;
    logic       rnd_en;
    logic       fp_en;
    logic       done;
    logic [1:0] key_sel;
    logic [1:0] pass;
    logic       mode_dec;
    logic [3:0] round;
    logic [1:0] shift_amt;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic dec = 1'b0;
  logic hold = 1'b0;

  logic       ready3, busy3, load3, key_load3, mode_dec3, rnd_en3, fp_en3, done3;
  logic [1:0] key_sel3, pass3, shift_amt3;
  logic [3:0] round3;
  logic       ready1, busy1, load1, key_load1, mode_dec1, rnd_en1, fp_en1, done1;
  logic [1:0] key_sel1, pass1, shift_amt1;
  logic [3:0] round1;

  always #5 clk = ~clk;

  tdes_round_ctrl #(.PASSES(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .dec(dec), .hold(hold),
    .ready(ready3), .busy(busy3), .load(load3), .key_load(key_load3),
    .key_sel(key_sel3), .pass(pass3), .mode_dec(mode_dec3), .rnd_en(rnd_en3),
    .round(round3), .shift_amt(shift_amt3), .fp_en(fp_en3), .done(done3)
  );

  tdes_round_ctrl #(.PASSES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .dec(dec), .hold(hold),
    .ready(ready1), .busy(busy1), .load(load1), .key_load(key_load1),
    .key_sel(key_sel1), .pass(pass1), .mode_dec(mode_dec1), .rnd_en(rnd_en1),
    .round(round1), .shift_amt(shift_amt1), .fp_en(fp_en1), .done(done1)
  );

  obs_t obs3, obs1;
  assign obs3 = '{ready3, busy3, load3, key_load3, rnd_en3, fp_en3, done3,
                  key_sel3, pass3, mode_dec3, round3, shift_amt3};
  assign obs1 = '{ready1, busy1, load1, key_load1, rnd_en1, fp_en1, done1,
                  key_sel1, pass1, mode_dec1, round1, shift_amt1};

  int n_checks = 0;
  int n_errors = 0;

  int key_enc3[3]   = '{0, 1, 2};
  int key_dec3[3]   = '{2, 1, 0};
  int mode_enc3[3]  = '{0, 1, 0};
  int mode_dec3t[3] = '{1, 0, 1};
  int shift_enc[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  int shift_dec[16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  obs_t exp_q[$];

  function automatic obs_t cur(input int w);
    return (w == 1) ? obs1 : obs3;
  endfunction

  function automatic obs_t idle_rec();
    obs_t r = '0;
    r.ready = 1'b1;
    return r;
  endfunction

  function automatic int ref_key(input int p, input bit d, input int pp);
    if (p == 1) return 0;
    return d ? key_dec3[pp] : key_enc3[pp];
  endfunction

  function automatic int ref_mode(input int p, input bit d, input int pp);
    if (p == 1) return int'(d);
    return d ? mode_dec3t[pp] : mode_enc3[pp];
  endfunction

  // Expected trace for one block, cycle 1 after the accepting edge onward,
  // with hl frozen/masked copies of entry h inserted for a hold window.
  task automatic build_exp(input int p, input bit d, input int h, input int hl);
    obs_t r, m;
    exp_q.delete();
    r = '0; r.busy = 1'b1; r.load = 1'b1; r.key_load = 1'b1;
    r.key_sel = 2'(ref_key(p, d, 0)); r.mode_dec = 1'(ref_mode(p, d, 0));
    exp_q.push_back(r);
    for (int pp = 0; pp < p; pp++) begin
      if (pp > 0) begin
        r = '0; r.busy = 1'b1; r.key_load = 1'b1; r.pass = 2'(pp);
        r.key_sel = 2'(ref_key(p, d, pp)); r.mode_dec = 1'(ref_mode(p, d, pp));
        exp_q.push_back(r);
      end
      for (int rr = 0; rr < 16; rr++) begin
        r = '0; r.busy = 1'b1; r.rnd_en = 1'b1; r.pass = 2'(pp); r.round = 4'(rr);
        r.key_sel = 2'(ref_key(p, d, pp)); r.mode_dec = 1'(ref_mode(p, d, pp));
        r.shift_amt = r.mode_dec ? 2'(shift_dec[rr]) : 2'(shift_enc[rr]);
        exp_q.push_back(r);
      end
    end
    r = '0; r.busy = 1'b1; r.fp_en = 1'b1; r.pass = 2'(p - 1);
    r.mode_dec = 1'(ref_mode(p, d, p - 1));
    exp_q.push_back(r);
    r = idle_rec(); r.done = 1'b1;
    exp_q.push_back(r);
    if (hl > 0) begin
      m = exp_q[h];
      m.load = 1'b0; m.key_load = 1'b0; m.rnd_en = 1'b0; m.fp_en = 1'b0;
      for (int k = 0; k < hl; k++) exp_q.insert(h, m);
    end
  endtask

  // Entered while the DUT is idle and before an edge; returns at the negedge
  // of the done cycle so a following call is a back-to-back launch.
  task automatic run_block(input int w, input bit d, input int h, input int hl,
                           input bit stray, input bit hold_acc, input string name);
    obs_t got;
    int p = (w == 1) ? 1 : 3;
    build_exp(p, d, h, hl);
    start = 1'b1; dec = d; hold = hold_acc;
    @(posedge clk); #1;
    start = 1'b0; hold = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      hold  = (hl > 0) && (i >= h) && (i < h + hl);
      start = stray && (i == 9);
      dec   = 1'($urandom);
      @(negedge clk);
      got = cur(w);
      n_checks++;
      if (got !== exp_q[i]) begin
        n_errors++;
        $display("FAIL %s cycle=%0d got=%h expected=%h", name, i + 1, got, exp_q[i]);
      end
      if (i < exp_q.size() - 1) begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0; hold = 1'b0;
  endtask

  task automatic idle_cycles(input int w, input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (cur(w) !== idle_rec()) begin
        n_errors++;
        $display("FAIL %s idle=%0d got=%h expected=%h", name, i, cur(w), idle_rec());
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (obs3 !== idle_rec()) begin
      n_errors++;
      $display("FAIL reset_p3 got=%h expected=%h", obs3, idle_rec());
    end
    n_checks++;
    if (obs1 !== idle_rec()) begin
      n_errors++;
      $display("FAIL reset_p1 got=%h expected=%h", obs1, idle_rec());
    end
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic test_single_pass();
    do_reset();
    run_block(1, 1'b0, 0, 0, 1'b0, 1'b0, "p1_enc");
    run_block(1, 1'b1, 0, 0, 1'b0, 1'b0, "p1_dec_b2b");
    idle_cycles(1, 2, "p1_after");
    run_block(1, 1'($urandom), 0, 0, 1'b1, 1'b0, "p1_rand");
    idle_cycles(1, 1, "p1_after2");
  endtask

  task automatic test_triple();
    do_reset();
    run_block(3, 1'b0, 0, 0, 1'b0, 1'b0, "p3_enc");
    idle_cycles(3, 2, "p3_enc_after");
    run_block(3, 1'b1, 0, 0, 1'b0, 1'b0, "p3_dec");
    idle_cycles(3, 1, "p3_dec_after");
  endtask

  task automatic test_hold();
    // pass 1 round 7 is trace entry 25 (cycle 26); done lands on cycle 58
    run_block(3, 1'b0, 25, 5, 1'b0, 1'b0, "hold_p1r7");
    idle_cycles(3, 1, "hold_after");
    run_block(3, 1'b1, 0, 0, 1'b0, 1'b1, "hold_in_idle");
    idle_cycles(3, 1, "hold_idle_after");
  endtask

  task automatic test_busy_start_and_back_to_back();
    run_block(3, 1'b0, 0, 0, 1'b1, 1'b0, "busy_start");
    run_block(3, 1'b1, 0, 0, 1'b1, 1'b0, "b2b_second");
    idle_cycles(3, 1, "b2b_after");
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      int h  = int'($urandom_range(0, 51));
      int hl = int'($urandom_range(0, 6));
      run_block(3, 1'($urandom), h, hl, 1'($urandom), 1'b0, "random");
      if ($urandom_range(0, 1) == 1) idle_cycles(3, 1, "random_gap");
    end
    idle_cycles(3, 1, "random_after");
  endtask

  task automatic test_reset_mid();
    obs_t got;
    bit d = 1'($urandom);
    build_exp(3, d, 0, 0);
    start = 1'b1; dec = d;
    @(posedge clk); #1;
    start = 1'b0;
    // pass 2 round 9 is trace entry 1 + 2*17 + 9
    for (int i = 0; i <= 44; i++) begin
      dec = 1'($urandom);
      @(negedge clk);
      got = obs3;
      n_checks++;
      if (got !== exp_q[i]) begin
        n_errors++;
        $display("FAIL reset_mid_pre cycle=%0d got=%h expected=%h", i + 1, got, exp_q[i]);
      end
      if (i < 44) begin
        @(posedge clk); #1;
      end
    end
    n_checks++;
    if (obs3 !== exp_q[44] || obs3.round !== 4'd9 || obs3.pass !== 2'd2) begin
      n_errors++;
      $display("FAIL reset_mid_point got=%h expected=%h", obs3, exp_q[44]);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs3 !== idle_rec()) begin
      n_errors++;
      $display("FAIL reset_async got=%h expected=%h", obs3, idle_rec());
    end
    @(posedge clk); #1; rst = 1'b0;
    idle_cycles(3, 20, "reset_no_done");
    run_block(3, 1'b0, 0, 0, 1'b0, 1'b0, "after_reset");
    idle_cycles(3, 1, "after_reset_idle");
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_triple();
    test_hold();
    test_busy_start_and_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
